sram_like_arbiter: RTL and testbench
====================================

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter NCH, default 2, number of upstream channels (legal 1..8; ch0 = inst, ch1 = data).
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width (multiple of 8); SW = DW/8.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 en  in  NCH  per-channel request valid.
REQ-007 wen  in  NCH*SW  per-channel byte write strobes; all-zero = read.
REQ-008 addr  in  NCH*AW  per-channel address.
REQ-009 wdata  in  NCH*DW  per-channel write data.
REQ-010 flush  in  NCH  per-channel discard of the in-flight transaction.
REQ-011 rdata  out  NCH*DW  per-channel registered read data.
REQ-012 stall  out  NCH  per-channel stall to the pipeline.
REQ-013 m_req  out  1  downstream request.
REQ-014 m_wr  out  1  downstream write (OR of granted wen).
REQ-015 m_wstrb  out  SW  granted wen.
REQ-016 m_addr  out  AW  granted addr.
REQ-017 m_wdata  out  DW  granted wdata.
REQ-018 m_addr_ok  in  1  downstream accepted request this cycle.
REQ-019 m_data_ok  in  1  downstream response/write-ack this cycle.
REQ-020 m_rdata  in  DW  downstream read data, valid with m_data_ok.

Function
REQ-021 FSM states IDLE, ADDR, DATA; one outstanding transaction at a time.
REQ-022 pending[c] = en[c] & ~done[c]; done[c] is a registered one-cycle pulse.
REQ-023 stall[c] = en[c] & ~done[c], combinational; upstream holds en/wen/addr/wdata stable while stall[c] high.
REQ-024 IDLE, any pending: grant = first pending channel searching round-robin from ptr+1 (mod NCH); register grant, ptr <= grant, go ADDR.
REQ-025 IDLE, none pending: stay IDLE, m_req 0.
REQ-026 ADDR: m_req = 1, m_* driven from granted channel's live inputs; m_addr_ok -> DATA; else stay ADDR.
REQ-027 ADDR: m_req never withdrawn before m_addr_ok, regardless of flush or en.
REQ-028 DATA: m_req = 0; on m_data_ok -> IDLE, and unless discarded: done[grant] <= 1, rdata[grant] <= m_rdata (reads only; writes leave rdata unchanged).
REQ-029 m_data_ok in IDLE/ADDR ignored; m_addr_ok outside ADDR ignored.
REQ-030 flush[grant] high in ADDR or DATA sets discard flag; transaction still completes downstream; no done pulse, no rdata update; discard cleared on IDLE entry.
REQ-031 flush on a non-granted channel or in IDLE: no effect on FSM.
REQ-032 Minimum latency: en rising in IDLE -> stall low 3 cycles later (IDLE, ADDR w/ addr_ok, DATA w/ data_ok, done).
REQ-033 Channel receiving done is not regranted in the done cycle (pending low); back-to-back requests on one channel see one idle cycle between transactions.
REQ-034 Fairness: with all channels continuously pending, grants rotate 0,1,..,NCH-1,0.
REQ-035 NCH = 1: ptr logic degenerates; always grant ch0.

Reset
REQ-036 resetn low, asynchronously: state IDLE, m_req 0, done 0, discard 0, rdata all 0, grant 0, ptr NCH-1 (ch0 first).
REQ-037 Reset mid-transaction abandons it; no done pulse follows; downstream responsible for its own reset.
REQ-038 m_wr, m_wstrb, m_addr, m_wdata are don't-care while m_req 0 but drive from grant (0 in reset).

Verification
REQ-039 Single read: en[0]=1, addr=0xBFC00000, addr_ok immediate, data_ok next cycle with 0x3C1D8000 -> stall[0] high 3 cycles, rdata[0]=0x3C1D8000 in done cycle.
REQ-040 Contention: en=2'b11 from reset -> ch0 granted first, then ch1; both complete, each done exactly once.
REQ-041 Write: en[1]=1, wen[1]=4'b0011, wdata=0xDEADBEEF -> m_wr=1, m_wstrb=4'b0011, rdata[1] unchanged after done.
REQ-042 Backpressure: addr_ok delayed 4 cycles, data_ok delayed 3 -> m_req held 5 cycles stable, stall released only after data_ok.
REQ-043 Flush: flush[1] pulse in DATA -> data_ok consumed, no done[1], rdata[1] unchanged, FSM returns IDLE, next pending channel granted.
REQ-044 Reset mid-ADDR: resetn low while m_req=1 -> m_req 0 immediately, all stall follow en only, rdata 0.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Round-robin arbiter merging NCH SRAM-like request channels onto one
// downstream SRAM-like port, one outstanding transaction at a time.
module sram_like_arbiter #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NCH-1:0]          en,
    input  logic [NCH*(DW/8)-1:0]   wen,
    input  logic [NCH*AW-1:0]       addr,
    input  logic [NCH*DW-1:0]       wdata,
    input  logic [NCH-1:0]          flush,
    output logic [NCH*DW-1:0]       rdata,
    output logic [NCH-1:0]          stall,
    output logic                    m_req,
    output logic                    m_wr,
    output logic [DW/8-1:0]         m_wstrb,
    output logic [AW-1:0]           m_addr,
    output logic [DW-1:0]           m_wdata,
    input  logic                    m_addr_ok,
    input  logic                    m_data_ok,
    input  logic [DW-1:0]           m_rdata
);

    localparam int SW = DW / 8;
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e              state_q;
    logic                m_req_q;
    logic [GW-1:0]       grant_q;
    logic [GW-1:0]       ptr_q;
    logic                discard_q;
    logic                discard_d;
    logic [NCH-1:0]      done_q;
    logic [NCH-1:0]      done_d;
    logic [NCH*DW-1:0]   rdata_q;
    logic [NCH*DW-1:0]   rdata_d;

    logic [NCH-1:0]      pending_s;
    logic                pick_valid_s;
    logic [GW-1:0]       pick_idx_s;
    logic [SW-1:0]       g_wen_s;
    logic [AW-1:0]       g_addr_s;
    logic [DW-1:0]       g_wdata_s;
    logic                g_flush_s;
    logic                g_wr_s;
    logic                complete_s;

    // A channel that just received its done pulse is not pending for that cycle.
    assign pending_s = en & ~done_q;
    assign stall     = pending_s;

    // Granted channel's live request fields.
    assign g_wen_s   = wen[grant_q*SW +: SW];
    assign g_addr_s  = addr[grant_q*AW +: AW];
    assign g_wdata_s = wdata[grant_q*DW +: DW];
    assign g_flush_s = flush[grant_q];
    assign g_wr_s    = |g_wen_s;

    assign m_req   = m_req_q;
    assign m_wr    = g_wr_s;
    assign m_wstrb = g_wen_s;
    assign m_addr  = g_addr_s;
    assign m_wdata = g_wdata_s;
    assign rdata   = rdata_q;

    // Round-robin pick: first pending channel starting just after ptr.
    always_comb begin
        int cand;
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        cand         = 0;
        for (int i = 1; i <= NCH; i++) begin
            cand = (int'(ptr_q) + i) % NCH;
            if (!pick_valid_s && pending_s[cand]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = GW'(cand);
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // Completion: done pulse and read-data capture unless the transaction was flushed.
    always_comb begin
        done_d     = '0;
        rdata_d    = rdata_q;
        complete_s = (state_q == ST_DATA) && m_data_ok;
        // A flush arriving in the completion cycle itself still discards.
        discard_d  = discard_q | ((state_q != ST_IDLE) & g_flush_s);
        if (complete_s && !discard_d) begin
            done_d[grant_q] = 1'b1;
            if (!g_wr_s) begin
                rdata_d[grant_q*DW +: DW] = m_rdata;
            end else begin
                rdata_d = rdata_q;
            end
        end else begin
            done_d = '0;
        end
    end

    // Done pulse and per-channel read data registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done_q  <= '0;
            rdata_q <= '0;
        end else begin
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    // Transaction FSM: IDLE -> ADDR (request held until accepted) -> DATA.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            m_req_q   <= 1'b0;
            grant_q   <= '0;
            ptr_q     <= GW'(NCH - 1);
            discard_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    discard_q <= 1'b0;
                    if (pick_valid_s) begin
                        grant_q <= pick_idx_s;
                        ptr_q   <= pick_idx_s;
                        m_req_q <= 1'b1;
                        state_q <= ST_ADDR;
                    end else begin
                        m_req_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    discard_q <= discard_d;
                    if (m_addr_ok) begin
                        m_req_q <= 1'b0;
                        state_q <= ST_DATA;
                    end else begin
                        m_req_q <= 1'b1;
                        state_q <= ST_ADDR;
                    end
                end
                ST_DATA: begin
                    m_req_q <= 1'b0;
                    if (m_data_ok) begin
                        discard_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        discard_q <= discard_d;
                        state_q   <= ST_DATA;
                    end
                end
                default: begin
                    m_req_q   <= 1'b0;
                    discard_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed testbench for sram_like_arbiter (NCH=2, AW=32, DW=32) with
// hand-computed expectations checked by immediate assertions.
module tb_sram_like_arbiter;

    logic        clk;
    logic        resetn;
    logic [1:0]  en;
    logic [7:0]  wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  flush;
    logic [63:0] rdata;
    logic [1:0]  stall;
    logic        m_req;
    logic        m_wr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    int vectors;
    int miscompares;

    sram_like_arbiter #(.NCH(2), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .wen       (wen),
        .addr      (addr),
        .wdata     (wdata),
        .flush     (flush),
        .rdata     (rdata),
        .stall     (stall),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_wstrb   (m_wstrb),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        en          = 2'b00;
        wen         = 8'h00;
        addr        = 64'h0;
        wdata       = 64'h0;
        flush       = 2'b00;
        m_addr_ok   = 1'b0;
        m_data_ok   = 1'b0;
        m_rdata     = 32'h0;
        tick();
        tick();
        #1;
        chk("rst_m_req", {63'h0, m_req}, 64'h0);
        chk("rst_stall", {62'h0, stall}, 64'h0);
        chk("rst_rdata", rdata, 64'h0);
        resetn = 1'b1;
        tick();

        // Single read on ch0, immediate addr_ok, data_ok one cycle later
        en   = 2'b01;
        addr = 64'h0000_0000_BFC0_0000;
        #1;
        chk("rd_idle_stall", {62'h0, stall}, 64'h1);
        chk("rd_idle_m_req", {63'h0, m_req}, 64'h0);
        tick();
        chk("rd_addr_m_req", {63'h0, m_req}, 64'h1);
        chk("rd_addr_m_addr", {32'h0, m_addr}, 64'hBFC0_0000);
        chk("rd_addr_m_wr", {63'h0, m_wr}, 64'h0);
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        m_rdata   = 32'h3C1D_8000;
        #1;
        chk("rd_data_m_req", {63'h0, m_req}, 64'h0);
        chk("rd_data_stall", {62'h0, stall}, 64'h1);
        tick();
        m_data_ok = 1'b0;
        m_rdata   = 32'h0;
        #1;
        chk("rd_done_stall", {62'h0, stall}, 64'h0);
        chk("rd_done_rdata", rdata, 64'h0000_0000_3C1D_8000);
        en = 2'b00;
        tick();

        // Write on ch1: strobes forwarded, rdata[1] untouched
        en    = 2'b10;
        wen   = 8'h30;
        addr  = 64'h1000_0040_0000_0000;
        wdata = 64'hDEAD_BEEF_0000_0000;
        tick();
        chk("wr_m_req", {63'h0, m_req}, 64'h1);
        chk("wr_m_wr", {63'h0, m_wr}, 64'h1);
        chk("wr_m_wstrb", {60'h0, m_wstrb}, 64'h3);
        chk("wr_m_addr", {32'h0, m_addr}, 64'h1000_0040);
        chk("wr_m_wdata", {32'h0, m_wdata}, 64'hDEAD_BEEF);
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        m_rdata   = 32'h1234_5678;
        tick();
        m_data_ok = 1'b0;
        #1;
        chk("wr_done_stall", {62'h0, stall}, 64'h0);
        chk("wr_done_rdata", rdata, 64'h0000_0000_3C1D_8000);
        en    = 2'b00;
        wen   = 8'h00;
        wdata = 64'h0;
        tick();

        // Contention from reset: ch0 first, then ch1, then ch1 again after one idle cycle
        resetn = 1'b0;
        #1;
        chk("rst2_rdata", rdata, 64'h0);
        tick();
        resetn = 1'b1;
        en     = 2'b11;
        addr   = 64'h0000_0200_0000_0100;
        tick();
        chk("ct_grant0_addr", {32'h0, m_addr}, 64'h100);
        chk("ct_grant0_stall", {62'h0, stall}, 64'h3);
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        m_rdata   = 32'hAAAA_0000;
        tick();
        m_data_ok = 1'b0;
        #1;
        chk("ct_done0_stall", {62'h0, stall}, 64'h2);
        chk("ct_done0_rdata", rdata, 64'h0000_0000_AAAA_0000);
        en = 2'b10;
        tick();
        chk("ct_grant1_m_req", {63'h0, m_req}, 64'h1);
        chk("ct_grant1_addr", {32'h0, m_addr}, 64'h200);
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        m_rdata   = 32'hBBBB_1111;
        tick();
        m_data_ok = 1'b0;
        #1;
        chk("ct_done1_stall", {62'h0, stall}, 64'h0);
        chk("ct_done1_rdata", rdata, 64'hBBBB_1111_AAAA_0000);
        chk("ct_done1_m_req", {63'h0, m_req}, 64'h0);
        tick();
        chk("b2b_gap_stall", {62'h0, stall}, 64'h2);
        chk("b2b_gap_m_req", {63'h0, m_req}, 64'h0);
        tick();
        chk("b2b_addr_m_req", {63'h0, m_req}, 64'h1);
        chk("b2b_addr_m_addr", {32'h0, m_addr}, 64'h200);
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        m_rdata   = 32'hCCCC_2222;
        tick();
        m_data_ok = 1'b0;
        en        = 2'b00;
        #1;
        chk("b2b_done_rdata", rdata, 64'hCCCC_2222_AAAA_0000);
        tick();

        // Stray handshakes in IDLE are ignored
        m_addr_ok = 1'b1;
        m_data_ok = 1'b1;
        m_rdata   = 32'hFFFF_FFFF;
        tick();
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        #1;
        chk("idle_ign_m_req", {63'h0, m_req}, 64'h0);
        chk("idle_ign_rdata", rdata, 64'hCCCC_2222_AAAA_0000);

        // Backpressure: addr_ok after 4 wait cycles, data_ok after 3 wait cycles
        en   = 2'b01;
        addr = 64'h0000_0000_0000_0300;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("bp_addr_m_req", {63'h0, m_req}, 64'h1);
            chk("bp_addr_m_addr", {32'h0, m_addr}, 64'h300);
            tick();
        end
        m_addr_ok = 1'b1;
        #1;
        chk("bp_addr5_m_req", {63'h0, m_req}, 64'h1);
        tick();
        m_addr_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_data_m_req", {63'h0, m_req}, 64'h0);
            chk("bp_data_stall", {62'h0, stall}, 64'h1);
            tick();
        end
        m_data_ok = 1'b1;
        m_rdata   = 32'hDDDD_3333;
        #1;
        chk("bp_dok_stall", {62'h0, stall}, 64'h1);
        tick();
        m_data_ok = 1'b0;
        #1;
        chk("bp_done_stall", {62'h0, stall}, 64'h0);
        chk("bp_done_rdata", rdata, 64'hCCCC_2222_DDDD_3333);
        en = 2'b00;
        tick();

        // Flush ch1 in DATA: no done, rdata kept, ch0 granted next
        en   = 2'b10;
        addr = 64'h0000_0400_0000_0500;
        tick();
        chk("fl_addr_m_addr", {32'h0, m_addr}, 64'h400);
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        flush     = 2'b10;
        en        = 2'b11;
        tick();
        flush     = 2'b00;
        m_data_ok = 1'b1;
        m_rdata   = 32'hEEEE_4444;
        #1;
        chk("fl_dok_stall", {62'h0, stall}, 64'h3);
        tick();
        m_data_ok = 1'b0;
        #1;
        chk("fl_idle_stall", {62'h0, stall}, 64'h3);
        chk("fl_idle_rdata", rdata, 64'hCCCC_2222_DDDD_3333);
        chk("fl_idle_m_req", {63'h0, m_req}, 64'h0);
        en = 2'b01;
        tick();
        chk("fl_next_m_req", {63'h0, m_req}, 64'h1);
        chk("fl_next_m_addr", {32'h0, m_addr}, 64'h500);
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        m_rdata   = 32'h5555_AAAA;
        tick();
        m_data_ok = 1'b0;
        en        = 2'b00;
        #1;
        chk("fl_next_rdata", rdata, 64'hCCCC_2222_5555_AAAA);
        tick();

        // Reset while a request is held in ADDR
        en   = 2'b11;
        addr = 64'h0000_0600_0000_0700;
        tick();
        chk("rma_m_req", {63'h0, m_req}, 64'h1);
        resetn = 1'b0;
        #1;
        chk("rma_m_req_rst", {63'h0, m_req}, 64'h0);
        chk("rma_stall_rst", {62'h0, stall}, 64'h3);
        chk("rma_rdata_rst", rdata, 64'h0);
        en = 2'b01;
        #1;
        chk("rma_stall_en", {62'h0, stall}, 64'h1);
        tick();
        en     = 2'b00;
        resetn = 1'b1;
        m_data_ok = 1'b1;
        m_rdata   = 32'h9999_9999;
        tick();
        m_data_ok = 1'b0;
        tick();
        chk("rma_after_rdata", rdata, 64'h0);
        chk("rma_after_m_req", {63'h0, m_req}, 64'h0);
        chk("rma_after_stall", {62'h0, stall}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
